// File: rtl/xbar_out_sched_if.sv
// Port bundle for one crossbar output scheduler: requester beats in,
// registered beat plus credit status out.
interface xbar_out_sched_if #(
  parameter int N = 8,
  parameter int W = 64
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [SW-1:0]  out_src;
  logic           credit_return;
  logic [3:0]     credit_cnt;
  logic           err_credit_ovf;

  modport master (
    output req_valid, req_last, req_data, credit_return,
    input  req_ready, out_valid, out_data, out_last, out_src,
           credit_cnt, err_credit_ovf
  );

  modport slave (
    input  req_valid, req_last, req_data, credit_return,
    output req_ready, out_valid, out_data, out_last, out_src,
           credit_cnt, err_credit_ovf
  );
endinterface

// File: rtl/xbar_out_sched.sv
// Packet-atomic round-robin scheduler for one crossbar output, throttled by
// downstream buffer credits; the winning beat is registered one cycle later.
module xbar_out_sched #(
  parameter int N       = 8,
  parameter int W       = 64,
  parameter int CREDITS = 4
) (
  input logic              clk,
  input logic              rst_n,
  xbar_out_sched_if.slave  bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  localparam logic [3:0] CRED_MAX = 4'(CREDITS);

  logic [0:0]    state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] owner_q, owner_d;
  logic [3:0]    credit_q, credit_d;
  logic          err_q, err_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_src_q, out_src_d;

  logic [SW-1:0] sel;
  logic          sel_any;
  logic          accept;
  logic          sel_last;
  logic [W-1:0]  sel_data;
  int            idx;

  // Locked: only the owner competes. Idle: scan downward so the requester
  // closest to ptr (in wrap order) is the last one written and wins.
  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    sel     = '0;
    sel_any = 1'b0;
    idx     = 0;
    if (state_q == LOCKED) begin
      sel     = owner_q;
      sel_any = bus.req_valid[owner_q];
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = int'(ptr_q) + k;
        if (idx >= N) idx = idx - N;
        if (bus.req_valid[idx]) begin
          sel     = SW'(idx);
          sel_any = 1'b1;
        end
      end
    end
  end

  // rst_n gates the grant so req_ready is zero for the whole reset window.
  assign accept   = sel_any && (credit_q != 4'd0) && rst_n;
  assign sel_last = bus.req_last[sel];
  assign sel_data = bus.req_data[int'(sel)*W +: W];

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[sel] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (accept) begin
      if (sel_last) begin
        state_d = IDLE;
        ptr_d   = (int'(sel) == N - 1) ? '0 : sel + 1'b1;
      end else begin
        state_d = LOCKED;
        owner_d = sel;
      end
    end
  end

  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    case ({accept, bus.credit_return})
      2'b10:   credit_d = credit_q - 4'd1;
      2'b01: begin
        if (credit_q == CRED_MAX) err_d = 1'b1;
        else                      credit_d = credit_q + 4'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    out_valid_d = accept;
    out_last_d  = accept & sel_last;
    out_data_d  = accept ? sel_data : '0;
    out_src_d   = accept ? sel : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      credit_q    <= CRED_MAX;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      credit_q    <= credit_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.out_last       = out_last_q;
  assign bus.out_data       = out_data_q;
  assign bus.out_src        = out_src_q;
  assign bus.credit_cnt     = credit_q;
  assign bus.err_credit_ovf = err_q;
endmodule

// File: tb/tb_xbar_out_sched.sv
// Self-checking bench: a packet-level reference model checks every cycle,
// directed scenarios pin the model with literal grant orders.
module tb_xbar_out_sched;
  localparam int N       = 4;
  localparam int W       = 16;
  localparam int CREDITS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xbar_out_sched_if #(.N(N), .W(W)) bus ();

  xbar_out_sched #(.N(N), .W(W), .CREDITS(CREDITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner (-1 = nobody), round-robin pointer, credit count.
  int          m_owner = -1;
  int          m_ptr   = 0;
  int          m_cred  = CREDITS;
  bit          m_err   = 1'b0;
  bit          m_ov    = 1'b0;
  logic [W-1:0] m_od   = '0;
  bit          m_ol    = 1'b0;
  int          m_os    = 0;
  int          m_log[$];
  int          dut_log[$];

  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    int g;
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_cred = CREDITS; m_err = 1'b0; m_ov = 1'b0;
      check("rst_out_data", 64'(bus.out_data), 64'd0);
      check("rst_out_src", 64'(bus.out_src), 64'd0);
      check("rst_out_last", 64'(bus.out_last), 64'd0);
    end
    g = -1;
    if (rst_n && m_cred > 0) begin
      if (m_owner >= 0) begin
        if (bus.req_valid[m_owner]) g = m_owner;
      end else begin
        for (int k = 0; k < N; k++)
          if (g < 0 && bus.req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;

    check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    check("out_valid", 64'(bus.out_valid), 64'(m_ov));
    if (m_ov) begin
      check("out_data", 64'(bus.out_data), 64'(m_od));
      check("out_last", 64'(bus.out_last), 64'(m_ol));
      check("out_src", 64'(bus.out_src), 64'(m_os));
    end
    check("credit_cnt", 64'(bus.credit_cnt), 64'(m_cred));
    check("err_credit_ovf", 64'(bus.err_credit_ovf), 64'(m_err));
    if (bus.out_valid) dut_log.push_back(int'(bus.out_src));

    if (rst_n) begin
      m_ov = (g >= 0);
      if (g >= 0) begin
        m_od = bus.req_data[g*W +: W];
        m_ol = bus.req_last[g];
        m_os = g;
        m_log.push_back(g);
        if (bus.req_last[g]) begin
          m_owner = -1;
          m_ptr   = (g + 1) % N;
        end else begin
          m_owner = g;
        end
      end
      if (g >= 0 && !bus.credit_return) m_cred--;
      else if (g < 0 && bus.credit_return) begin
        if (m_cred == CREDITS) m_err = 1'b1;
        else m_cred++;
      end
    end
  end

  // Random-phase packet bookkeeping (lengths 1..4 beats per requester).
  int len[N];
  int beat[N];

  task automatic tick();
    logic [N-1:0] hs;
    @(negedge clk); #1;
    hs = bus.req_valid & bus.req_ready;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        if (beat[i] >= len[i] - 1) begin
          beat[i] = 0;
          len[i]  = $urandom_range(1, 4);
        end else beat[i]++;
      end
    end
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic ret);
    bus.req_valid     = v;
    bus.req_last      = l;
    bus.credit_return = ret;
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = W'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive('0, '0, 1'b0);
    for (int i = 0; i < N; i++) begin beat[i] = 0; len[i] = $urandom_range(1, 4); end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic clear_logs();
    m_log.delete();
    dut_log.delete();
  endtask

  task automatic check_seq(input string name, input int exp[$]);
    check({name, "_dut_len"}, 64'(dut_log.size()), 64'(exp.size()));
    check({name, "_model_len"}, 64'(m_log.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < dut_log.size()) check({name, "_dut_src"}, 64'(dut_log[i]), 64'(exp[i]));
      if (i < m_log.size())   check({name, "_model_src"}, 64'(m_log[i]), 64'(exp[i]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    drive('0, '0, 1'b0);
    do_reset();
    #1;
    check("reset_credit", 64'(bus.credit_cnt), 64'd4);
    check("reset_err", 64'(bus.err_credit_ovf), 64'd0);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);

    // All valid, single-beat, credit returned alongside every accept.
    clear_logs();
    for (int c = 0; c < 5; c++) begin drive(4'b1111, 4'b1111, 1'b1); tick(); end
    drive('0, '0, 1'b0); tick();
    check_seq("rr_order", '{0, 1, 2, 3, 0});
    check("rr_credit", 64'(bus.credit_cnt), 64'd4);

    // Requester 2 sends 3 beats while requester 0 waits (ptr is now 1).
    clear_logs();
    for (int c = 0; c < 3; c++) begin
      drive(4'b0101, (c == 2) ? 4'b0100 : 4'b0000, 1'b0);
      #1 check("pkt_ready_owner", 64'(bus.req_ready), 64'b0100);
      tick();
    end
    drive(4'b0001, 4'b0001, 1'b0); tick();
    drive('0, '0, 1'b0); tick();
    check_seq("pkt_atomic", '{2, 2, 2, 0});
    check("pkt_credit_empty", 64'(bus.credit_cnt), 64'd0);
    for (int c = 0; c < 4; c++) begin drive('0, '0, 1'b1); tick(); end
    drive('0, '0, 1'b0); tick();
    check("pkt_credit_refill", 64'(bus.credit_cnt), 64'd4);

    // Credit exhaustion with requester 1 streaming.
    do_reset();
    clear_logs();
    for (int c = 0; c < 6; c++) begin drive(4'b0010, 4'b0010, 1'b0); tick(); end
    #1;
    check("starve_ready", 64'(bus.req_ready), 64'd0);
    check("starve_model_len", 64'(m_log.size()), 64'd4);
    drive(4'b0010, 4'b0010, 1'b1); tick();
    for (int c = 0; c < 3; c++) begin drive(4'b0010, 4'b0010, 1'b0); tick(); end
    drive('0, '0, 1'b0); tick();
    check_seq("starve", '{1, 1, 1, 1, 1});

    // Owner bubbles while requester 1 is valid.
    do_reset();
    clear_logs();
    for (int c = 0; c < 2; c++) begin drive(4'b0011, 4'b0000, 1'b0); tick(); end
    for (int c = 0; c < 2; c++) begin
      drive(4'b0010, 4'b0010, 1'b0);
      #1 check("bubble_ready", 64'(bus.req_ready), 64'd0);
      tick();
    end
    drive(4'b0011, 4'b0001, 1'b0);
    #1 check("bubble_resume", 64'(bus.req_ready), 64'b0001);
    tick();
    drive(4'b0010, 4'b0010, 1'b0); tick();
    drive('0, '0, 1'b0); tick();
    check_seq("bubble", '{0, 0, 0, 1});

    // Credit overflow is sticky until reset.
    do_reset();
    drive('0, '0, 1'b1); tick();
    drive('0, '0, 1'b0); tick();
    check("ovf_credit", 64'(bus.credit_cnt), 64'd4);
    check("ovf_flag", 64'(bus.err_credit_ovf), 64'd1);
    for (int c = 0; c < 3; c++) tick();
    check("ovf_sticky", 64'(bus.err_credit_ovf), 64'd1);
    do_reset();
    #1 check("ovf_cleared", 64'(bus.err_credit_ovf), 64'd0);

    // Reset in the middle of a 4-beat packet from requester 2.
    drive(4'b0010, 4'b0010, 1'b0); tick();
    drive(4'b0100, 4'b0000, 1'b0); tick();
    tick();
    check("midrst_pre_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_credit", 64'(bus.credit_cnt), 64'd4);
    check("midrst_ready", 64'(bus.req_ready), 64'd0);
    check("midrst_src", 64'(bus.out_src), 64'd0);
    drive('0, '0, 1'b0);
    for (int i = 0; i < N; i++) beat[i] = 0;
    tick();
    rst_n = 1'b1;
    drive(4'b0101, 4'b0101, 1'b0);
    #1 check("midrst_restart", 64'(bus.req_ready), 64'b0001);
    tick();

    // Randomized traffic with one reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] v, l;
      if (c == 1500) do_reset();
      for (int i = 0; i < N; i++) begin
        v[i] = ($urandom_range(0, 99) < 60);
        l[i] = (beat[i] >= len[i] - 1);
      end
      drive(v, l, $urandom_range(0, 99) < 35);
      tick();
    end
    drive('0, '0, 1'b0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
